// File: rtl/stage2_message_sched.sv
// Beat sequencer for the stage-2 three-lane message mux: emits one m1/m2/m3 select triple per beat.
// Optional STAGE2_SCHED_PERF_EN adds a saturating 16-bit stall_cnt output.
module stage2_message_sched #(
  parameter int unsigned CTRL_W  = 3,
  parameter int unsigned ROUND_W = 8,
  parameter int unsigned STEP_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [ROUND_W-1:0] rounds,
  input  logic               abort,
  input  logic               msg_ready,
  output logic               msg_valid,
  output logic [CTRL_W-1:0]  mux_ctrl_m1,
  output logic [CTRL_W-1:0]  mux_ctrl_m2,
  output logic [CTRL_W-1:0]  mux_ctrl_m3,
  output logic [STEP_W-1:0]  step_cnt,
  output logic               busy,
  output logic               done
`ifdef STAGE2_SCHED_PERF_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  localparam int unsigned TRIPLE_W = 3 * CTRL_W;
  localparam int unsigned STALL_W  = 16;

  localparam logic [CTRL_W-1:0] SEL_A = CTRL_W'(1);
  localparam logic [CTRL_W-1:0] SEL_D = CTRL_W'(2);
  localparam logic [CTRL_W-1:0] SEL_K = CTRL_W'(3);
  localparam logic [CTRL_W-1:0] SEL_Q = CTRL_W'(4);
  localparam logic [CTRL_W-1:0] SEL_N = CTRL_W'(5);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [STEP_W-1:0]     last_q, last_d;
  logic [STEP_W-1:0]     step_q, step_d;
  logic [STEP_W-1:0]     step_nxt;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [TRIPLE_W-1:0]   triple_q, triple_d;

  // Select triple {m1,m2,m3} for a given schedule and beat index.
  function automatic logic [TRIPLE_W-1:0] sched_triple(input logic [1:0]        md,
                                                       input logic [STEP_W-1:0] idx);
    logic [TRIPLE_W-1:0] t;
    t = '0;
    case (md)
      2'd0: begin
        case (idx)
          STEP_W'(0): t = {SEL_A, SEL_D, SEL_K};
          STEP_W'(1): t = {SEL_Q, SEL_N, SEL_A};
          default:    t = '0;
        endcase
      end
      2'd1: begin
        case (idx)
          STEP_W'(0): t = {SEL_A, SEL_A, SEL_A};
          STEP_W'(1): t = {SEL_D, SEL_D, SEL_D};
          STEP_W'(2): t = {SEL_K, SEL_K, SEL_K};
          STEP_W'(3): t = {SEL_Q, SEL_Q, SEL_Q};
          STEP_W'(4): t = {SEL_N, SEL_N, SEL_N};
          default:    t = '0;
        endcase
      end
      2'd2: begin
        case (idx)
          STEP_W'(0): t = {SEL_N, SEL_Q, SEL_K};
          STEP_W'(1): t = {SEL_D, SEL_A, SEL_N};
          STEP_W'(2): t = {SEL_K, SEL_K, SEL_Q};
          default:    t = '0;
        endcase
      end
      default: t = {SEL_A, SEL_N, SEL_N};
    endcase
    return t;
  endfunction

  // Index of the final beat; repeat mode treats a zero round count as one beat.
  function automatic logic [STEP_W-1:0] last_index(input logic [1:0]         md,
                                                   input logic [ROUND_W-1:0] rnd);
    logic [STEP_W-1:0] l;
    case (md)
      2'd0:    l = STEP_W'(1);
      2'd1:    l = STEP_W'(4);
      2'd2:    l = STEP_W'(2);
      default: l = (rnd == '0) ? '0 : STEP_W'(rnd - ROUND_W'(1));
    endcase
    return l;
  endfunction

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    last_d   = last_q;
    step_d   = step_q;
    valid_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    triple_d = '0;
    step_nxt = step_q + STEP_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d  = ST_RUN;
          mode_d   = mode;
          last_d   = last_index(mode, rounds);
          step_d   = '0;
          valid_d  = 1'b1;
          busy_d   = 1'b1;
          triple_d = sched_triple(mode, '0);
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          step_d  = '0;
        end else if (msg_ready) begin
          if (step_q == last_q) begin
            state_d = ST_DONE;
            step_d  = '0;
            done_d  = 1'b1;
          end else begin
            step_d   = step_nxt;
            valid_d  = 1'b1;
            busy_d   = 1'b1;
            triple_d = sched_triple(mode_q, step_nxt);
          end
        end else begin
          valid_d  = 1'b1;
          busy_d   = 1'b1;
          triple_d = triple_q;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mode_q   <= '0;
      last_q   <= '0;
      step_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      triple_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      last_q   <= last_d;
      step_q   <= step_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      triple_q <= triple_d;
    end
  end

  assign msg_valid   = valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign step_cnt    = step_q;
  assign mux_ctrl_m1 = triple_q[TRIPLE_W-1 -: CTRL_W];
  assign mux_ctrl_m2 = triple_q[2*CTRL_W-1 -: CTRL_W];
  assign mux_ctrl_m3 = triple_q[CTRL_W-1:0];

`ifdef STAGE2_SCHED_PERF_EN
  logic [STALL_W-1:0] stall_q, stall_d;

  // Saturating count of stalled beats, cleared only by an accepted start.
  always_comb begin
    stall_d = stall_q;
    if (state_q == ST_IDLE && start && !abort) begin
      stall_d = '0;
    end else if (valid_q && !msg_ready && stall_q != '1) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_stage2_message_sched.sv
// Directed bench for stage2_message_sched with a beat scoreboard; honours STAGE2_SCHED_PERF_EN.
module tb_stage2_message_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] mode;
  logic [7:0] rounds;
  logic       abort;
  logic       msg_ready;
  logic       msg_valid;
  logic [2:0] mux_ctrl_m1, mux_ctrl_m2, mux_ctrl_m3;
  logic [7:0] step_cnt;
  logic       busy;
  logic       done;
`ifdef STAGE2_SCHED_PERF_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  stage2_message_sched #(.CTRL_W(3), .ROUND_W(8), .STEP_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mode        (mode),
    .rounds      (rounds),
    .abort       (abort),
    .msg_ready   (msg_ready),
    .msg_valid   (msg_valid),
    .mux_ctrl_m1 (mux_ctrl_m1),
    .mux_ctrl_m2 (mux_ctrl_m2),
    .mux_ctrl_m3 (mux_ctrl_m3),
    .step_cnt    (step_cnt),
    .busy        (busy),
    .done        (done)
`ifdef STAGE2_SCHED_PERF_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  typedef struct packed {
    logic [2:0] m1;
    logic [2:0] m2;
    logic [2:0] m3;
    logic [7:0] step;
  } beat_t;

  beat_t exp_q[$];
  int    n_pass = 0;
  int    n_chk  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int m1, input int m2, input int m3, input int st);
    beat_t b;
    b.m1 = 3'(m1); b.m2 = 3'(m2); b.m3 = 3'(m3); b.step = 8'(st);
    exp_q.push_back(b);
  endtask

  // Reference schedules: codes a=1 d=2 k=3 q=4 N=5.
  task automatic push_sched(input int md, input int rnd);
    case (md)
      0: begin push(1, 2, 3, 0); push(4, 5, 1, 1); end
      1: for (int i = 0; i < 5; i++) push(i + 1, i + 1, i + 1, i);
      2: begin push(5, 4, 3, 0); push(2, 1, 5, 1); push(3, 3, 4, 2); end
      default: for (int i = 0; i < ((rnd == 0) ? 1 : rnd); i++) push(1, 5, 5, i);
    endcase
  endtask

  task automatic do_start(input int md, input int rnd);
    mode   = 2'(md);
    rounds = 8'(rnd);
    start  = 1'b1;
    push_sched(md, rnd);
    tick();
    start = 1'b0;
`ifdef STAGE2_SCHED_PERF_EN
    chk("stall_clr_on_start", 32'(stall_cnt), 32'd0);
`endif
  endtask

  // Consume beats from the scoreboard until done; optional stall and mid-run start re-pulse.
  task automatic drain(input int stall_step, input int stall_n, input int repulse_step);
    int left;
    bit fin;
    left = stall_n;
    fin  = 1'b0;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      if (msg_valid) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 32'(msg_valid), 32'd0);
          msg_ready = 1'b1;
          fin = 1'b1;
        end else begin
          chk("triple", 32'({mux_ctrl_m1, mux_ctrl_m2, mux_ctrl_m3}),
              32'({exp_q[0].m1, exp_q[0].m2, exp_q[0].m3}));
          chk("step_cnt", 32'(step_cnt), 32'(exp_q[0].step));
          chk("busy_run", 32'(busy), 32'd1);
          if (32'(exp_q[0].step) == repulse_step) begin
            start = 1'b1; mode = 2'd2; rounds = 8'd9;
          end else begin
            start = 1'b0;
          end
          if (32'(exp_q[0].step) == stall_step && left > 0) begin
            msg_ready = 1'b0;
            left--;
          end else begin
            msg_ready = 1'b1;
            void'(exp_q.pop_front());
          end
        end
      end else if (done) begin
        start = 1'b0;
        chk("beats_left_at_done", 32'(exp_q.size()), 32'd0);
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("ctrl_at_done", 32'({mux_ctrl_m1, mux_ctrl_m2, mux_ctrl_m3}), 32'd0);
        fin = 1'b1;
        tick();
        chk("done_one_cycle", 32'({done, msg_valid, busy}), 32'd0);
      end else begin
        chk("stray_idle", 32'({msg_valid, done}), 32'd1);
        fin = 1'b1;
      end
      if (!fin) tick();
    end
    if (!fin) chk("drain_timeout", 32'd0, 32'd1);
    start = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 2'd0; rounds = 8'd0; abort = 1'b0; msg_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({msg_valid, busy, done, mux_ctrl_m1, mux_ctrl_m2, mux_ctrl_m3, step_cnt}), 32'd0);
    rst_n = 1'b1;
    tick();

    // mode 1, ready held high
    do_start(1, 0);
    drain(-1, 0, -1);

    // mode 0, ready low for 3 cycles on beat 0
    do_start(0, 0);
    drain(0, 3, -1);

    // mode 3 repeat counts, including zero
    do_start(3, 4);
    drain(-1, 0, -1);
    do_start(3, 0);
    drain(-1, 0, -1);

    // mode 2 aborted on beat 1 together with ready
    do_start(2, 0);
    chk("abort_b0", 32'({mux_ctrl_m1, mux_ctrl_m2, mux_ctrl_m3}),
        32'({exp_q[0].m1, exp_q[0].m2, exp_q[0].m3}));
    msg_ready = 1'b1;
    void'(exp_q.pop_front());
    tick();
    chk("abort_b1", 32'({mux_ctrl_m1, mux_ctrl_m2, mux_ctrl_m3, step_cnt}),
        32'({exp_q[0].m1, exp_q[0].m2, exp_q[0].m3, exp_q[0].step}));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_outputs", 32'({msg_valid, busy, done, mux_ctrl_m1, mux_ctrl_m2, mux_ctrl_m3, step_cnt}), 32'd0);
    tick();
    chk("abort_no_done", 32'({done, msg_valid}), 32'd0);
    exp_q.delete();
    do_start(0, 0);
    drain(-1, 0, -1);

    // abort in IDLE suppresses a simultaneous start
    start = 1'b1; abort = 1'b1; mode = 2'd1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("idle_abort_start", 32'({msg_valid, busy}), 32'd0);
    tick();
    chk("idle_abort_stays", 32'({msg_valid, busy, done}), 32'd0);

    // mode 1 with 7 stall cycles and a start re-pulse mid-run
    do_start(1, 0);
    drain(2, 7, 3);
`ifdef STAGE2_SCHED_PERF_EN
    chk("stall_cnt_after_done", 32'(stall_cnt), 32'd7);
`endif
    do_start(0, 0);
    drain(-1, 0, -1);

    // asynchronous reset at beat 2 of mode 1
    do_start(1, 0);
    msg_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_pre_step", 32'(step_cnt), 32'(exp_q[0].step));
      void'(exp_q.pop_front());
      tick();
    end
    chk("rst_at_beat2", 32'({mux_ctrl_m1, step_cnt}), 32'({exp_q[0].m1, exp_q[0].step}));
    rst_n = 1'b0;
    #1;
    chk("rst_immediate", 32'({msg_valid, busy, done, mux_ctrl_m1, mux_ctrl_m2, mux_ctrl_m3, step_cnt}), 32'd0);
`ifdef STAGE2_SCHED_PERF_EN
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rst_no_done", 32'({done, msg_valid, busy}), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
